stage_mem: RTL and testbench
============================

// Module: stage_mem
// PURPOSE
//  Memory stage, directly downstream of the execute stage. Holds the EX/MEM and MEM/WB pipeline registers.
//  Runs loads and stores against a handshaked data memory, with byte-lane alignment and sign/zero extension.
//  Raises me_stall while an access is outstanding. Exposes me_alu_out for forwarding back into execute.
// PARAMETERS
//  DMEM_TIMEOUT  255  max cycles in WAIT before abort with me_bus_err (range 1..255)
// PORTS
//  clk                input   1   clock; all state updates on rising edge
//  rst                input   1   reset; synchronous, active-high
//  ex_valid           input   1   execute slot holds a real instruction
//  ex_alu_out         input   32  ALU result / effective address
//  ex_rs2_data_st     input   32  store data, already forwarded
//  ex_func3           input   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_mem_read_ena    input   1   load
//  ex_mem_write_ena   input   1   store
//  ex_reg_write_ena   input   1   instruction writes rd
//  ex_rd              input   5   destination register
//  dmem_req           output  1   access request
//  dmem_we            output  1   1 = write
//  dmem_addr          output  32  word address, {addr[31:2],2'b00}
//  dmem_be            output  4   byte enables
//  dmem_wdata         output  32  lane-shifted store data
//  dmem_ready         input   1   access completes this cycle
//  dmem_rdata         input   32  read word, valid when dmem_ready
//  me_alu_out         output  32  EX/MEM address/result, forwarding source
//  me_rd              output  5   EX/MEM rd
//  me_reg_write_ena   output  1   EX/MEM reg write (qualified by valid)
//  me_stall           output  1   freeze IF/ID/EX and EX/MEM capture
//  me_misalign        output  1   1-cycle pulse: misaligned access dropped
//  me_bus_err         output  1   1-cycle pulse: access timed out
//  wb_reg_write_data  output  32  MEM/WB result
//  wb_rd              output  5   MEM/WB rd
//  wb_reg_write_ena   output  1   MEM/WB write enable
// BEHAVIOUR
//  Reset: all registered outputs 0, FSM = IDLE, timeout counter 0. dmem_req = 0, me_stall = 0.
//  EX/MEM capture: registered every cycle unless me_stall. ex_valid = 0 captures a bubble (all enables 0).
//  FSM states IDLE and WAIT:
//   - IDLE, valid mem op, aligned: dmem_req = 1 combinationally.
//     dmem_ready same cycle -> completes with zero stall.
//     Otherwise -> WAIT, me_stall = 1.
//   - WAIT: hold dmem_req and all dmem_* stable; me_stall = 1.
//     dmem_ready -> IDLE, me_stall = 0 that cycle.
//     Counter reaches DMEM_TIMEOUT -> IDLE, pulse me_bus_err, write to WB suppressed.
//  Misaligned access (H with addr[0] = 1, W with addr[1:0] != 0):
//   - no dmem_req, no stall, pulse me_misalign, wb_reg_write_ena = 0.
//  Byte enables by size: B -> 4'b0001 << addr[1:0]; H -> 4'b0011 << addr[1:0]; W -> 4'b1111.
//  Store data: byte/half replicated across all lanes. Loads drive dmem_we = 0.
//  Load data: select byte/half by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
//  Non-memory ops: wb_reg_write_data = me_alu_out, zero added latency.
//  MEM/WB: captured when stage completes (me_stall = 0). While stalled, a bubble is inserted (wb_reg_write_ena = 0).
//  Read and write both asserted: treated as store, read ignored.
//  rst mid-WAIT: FSM -> IDLE, dmem_req drops next cycle, any late dmem_ready ignored.
// TESTING
//  1. LW addr 0x100, dmem_ready same cycle, rdata 0xDEADBEEF
//     -> no stall; next cycle wb_reg_write_data = 0xDEADBEEF, wb_reg_write_ena = 1.
//  2. LB addr 0x103, rdata 0x80FF_0000, ready after 3 cycles
//     -> me_stall high 3 cycles; result 0xFFFFFF80.
//     Same access as LBU -> 0x00000080.
//  3. SH addr 0x202, data 0x1234ABCD
//     -> dmem_be = 4'b1100, dmem_wdata = 0xABCDABCD, dmem_we = 1, wb_reg_write_ena = 0.
//  4. LW addr 0x101
//     -> me_misalign pulse, dmem_req = 0, no WB write, next instruction flows unstalled.
//  5. DMEM_TIMEOUT = 4, dmem_ready held 0
//     -> stall 4 cycles, me_bus_err pulse, FSM back to IDLE.
//  6. rst asserted in WAIT
//     -> next cycle all outputs 0; dmem_ready pulse afterwards causes no WB write.

Source files
------------

// File: rtl/stage_mem.sv
// Memory stage: EX/MEM and MEM/WB pipeline registers around a handshaked data-memory access,
// with byte-lane alignment, load extension, misaligned-access drop and access timeout.
module stage_mem #(
   parameter int unsigned DMEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_rs2_data_st,
   input  logic [2:0]  ex_func3,
   input  logic        ex_mem_read_ena,
   input  logic        ex_mem_write_ena,
   input  logic        ex_reg_write_ena,
   input  logic [4:0]  ex_rd,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] me_alu_out,
   output logic [4:0]  me_rd,
   output logic        me_reg_write_ena,
   output logic        me_stall,
   output logic        me_misalign,
   output logic        me_bus_err,
   output logic [31:0] wb_reg_write_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write_ena
);
   localparam logic [7:0] TIMEOUT_C = 8'(DMEM_TIMEOUT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   lane_enables = 4'b0001 << off;
         2'b01:   lane_enables = 4'b0011 << off;
         default: lane_enables = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   store_lanes = {4{d[7:0]}};
         2'b01:   store_lanes = {2{d[15:0]}};
         default: store_lanes = d;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = off[0];
         default: misaligned = (off != 2'b00);
      endcase
   endfunction

   // Word lanes are shifted down first; word loads are always aligned so the shift is zero.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (f3)
         3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
         3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
         3'b100:  load_extend = {24'h000000, sh[7:0]};
         3'b101:  load_extend = {16'h0000, sh[15:0]};
         default: load_extend = sh;
      endcase
   endfunction

   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic        me_valid_r, me_read_r, me_write_r, me_reg_write_r;
   logic [31:0] me_alu_out_r, me_st_data_r;
   logic [2:0]  me_func3_r;
   logic [4:0]  me_rd_r;
   logic        wb_ena_r, misalign_r, bus_err_r;
   logic [31:0] wb_data_r;
   logic [4:0]  wb_rd_r;
   logic        mem_op_s, misalign_s, access_s;
   logic        req_s, stall_s, done_s, abort_s;
   logic [1:0]  lane_s;

   assign lane_s = me_alu_out_r[1:0];

   // Classify the instruction held in EX/MEM.
   always_comb begin
      mem_op_s   = me_valid_r & (me_read_r | me_write_r);
      misalign_s = mem_op_s & misaligned(me_func3_r[1:0], lane_s);
      access_s   = mem_op_s & ~misalign_s;
   end

   // Access FSM: cnt counts stalled cycles of the current access.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      req_s   = 1'b0;
      stall_s = 1'b0;
      done_s  = 1'b0;
      abort_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (access_s) begin
               req_s = 1'b1;
               if (dmem_ready) begin
                  done_s = 1'b1;
               end else begin
                  stall_s = 1'b1;
                  state_s = ST_WAIT;
                  cnt_s   = 8'd1;
               end
            end else begin
               cnt_s = 8'd0;
            end
         end
         ST_WAIT: begin
            req_s = 1'b1;
            if (dmem_ready) begin
               done_s  = 1'b1;
               state_s = ST_IDLE;
               cnt_s   = 8'd0;
            end else if (cnt_r >= TIMEOUT_C) begin
               abort_s = 1'b1;
               state_s = ST_IDLE;
               cnt_s   = 8'd0;
            end else begin
               stall_s = 1'b1;
               cnt_s   = cnt_r + 8'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
         end
      endcase
   end

   // FSM state and timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 8'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // EX/MEM register; frozen while the access is outstanding, bubbles carry no enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         me_valid_r     <= 1'b0;
         me_read_r      <= 1'b0;
         me_write_r     <= 1'b0;
         me_reg_write_r <= 1'b0;
         me_alu_out_r   <= 32'h0;
         me_st_data_r   <= 32'h0;
         me_func3_r     <= 3'b000;
         me_rd_r        <= 5'd0;
      end else if (!stall_s) begin
         me_valid_r     <= ex_valid;
         me_read_r      <= ex_valid & ex_mem_read_ena;
         me_write_r     <= ex_valid & ex_mem_write_ena;
         me_reg_write_r <= ex_valid & ex_reg_write_ena;
         me_alu_out_r   <= ex_alu_out;
         me_st_data_r   <= ex_rs2_data_st;
         me_func3_r     <= ex_func3;
         me_rd_r        <= ex_rd;
      end else begin
         me_valid_r <= me_valid_r;
      end
   end

   // MEM/WB register; faulted accesses never write back, a stall inserts a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_ena_r   <= 1'b0;
         wb_data_r  <= 32'h0;
         wb_rd_r    <= 5'd0;
         misalign_r <= 1'b0;
         bus_err_r  <= 1'b0;
      end else if (stall_s) begin
         wb_ena_r   <= 1'b0;
         misalign_r <= 1'b0;
         bus_err_r  <= 1'b0;
      end else begin
         wb_ena_r   <= me_valid_r & me_reg_write_r & ~misalign_s & ~abort_s;
         wb_data_r  <= (done_s & ~me_write_r) ? load_extend(me_func3_r, lane_s, dmem_rdata)
                                              : me_alu_out_r;
         wb_rd_r    <= me_rd_r;
         misalign_r <= misalign_s;
         bus_err_r  <= abort_s;
      end
   end

   assign dmem_req          = req_s;
   assign dmem_we           = req_s & me_write_r;
   assign dmem_addr         = req_s ? {me_alu_out_r[31:2], 2'b00} : 32'h0;
   assign dmem_be           = req_s ? lane_enables(me_func3_r[1:0], lane_s) : 4'b0000;
   assign dmem_wdata        = (req_s & me_write_r) ? store_lanes(me_func3_r[1:0], me_st_data_r) : 32'h0;
   assign me_alu_out        = me_alu_out_r;
   assign me_rd             = me_rd_r;
   assign me_reg_write_ena  = me_valid_r & me_reg_write_r;
   assign me_stall          = stall_s;
   assign me_misalign       = misalign_r;
   assign me_bus_err        = bus_err_r;
   assign wb_reg_write_data = wb_data_r;
   assign wb_rd             = wb_rd_r;
   assign wb_reg_write_ena  = wb_ena_r;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed scenarios then random loads/stores checked against a
// byte-addressed reference memory and a cycle-count model of the access timing.
module tb_stage_mem;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_mem_read_ena, ex_mem_write_ena, ex_reg_write_ena;
   logic [31:0] ex_alu_out, ex_rs2_data_st;
   logic [2:0]  ex_func3;
   logic [4:0]  ex_rd;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] me_alu_out, wb_reg_write_data;
   logic [4:0]  me_rd, wb_rd;
   logic        me_reg_write_ena, me_stall, me_misalign, me_bus_err, wb_reg_write_ena;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  ref_mem [int unsigned];
   logic [31:0] rsp_mem [int unsigned];
   logic        obs_req, obs_we;
   logic [3:0]  obs_be;
   logic [31:0] obs_wdata;

   stage_mem #(.DMEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
      .ex_rs2_data_st(ex_rs2_data_st), .ex_func3(ex_func3),
      .ex_mem_read_ena(ex_mem_read_ena), .ex_mem_write_ena(ex_mem_write_ena),
      .ex_reg_write_ena(ex_reg_write_ena), .ex_rd(ex_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .me_alu_out(me_alu_out), .me_rd(me_rd), .me_reg_write_ena(me_reg_write_ena),
      .me_stall(me_stall), .me_misalign(me_misalign), .me_bus_err(me_bus_err),
      .wb_reg_write_data(wb_reg_write_data), .wb_rd(wb_rd), .wb_reg_write_ena(wb_reg_write_ena)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int unsigned a);
      return a * 32'h9E3779B1 + 32'h0BADF00D;
   endfunction

   function automatic logic [7:0] ref_byte(input int unsigned a);
      logic [31:0] w;
      if (ref_mem.exists(a)) return ref_mem[a];
      w = init_word(a & ~32'd3);
      return 8'(w >> (8 * (a & 32'd3)));
   endfunction

   function automatic logic [31:0] rsp_word(input int unsigned wa);
      if (rsp_mem.exists(wa)) return rsp_mem[wa];
      return init_word(wa << 2);
   endfunction

   function automatic int size_bytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
   endfunction

   function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] addr);
      int n;
      logic [31:0] val;
      n = size_bytes(f3);
      val = 32'h0;
      for (int i = 0; i < n; i++) val = val | (32'(ref_byte(addr + 32'(i))) << (8 * i));
      if (!f3[2] && n < 4 && val[8 * n - 1]) val = val - (32'd1 << (8 * n));
      return val;
   endfunction

   task automatic preload(input logic [31:0] addr, input logic [31:0] word);
      rsp_mem[addr >> 2] = word;
      for (int i = 0; i < 4; i++) ref_mem[(addr & ~32'd3) + 32'(i)] = 8'(word >> (8 * i));
   endtask

   // Issue one instruction, answer its memory access after d cycles, check through write-back.
   task automatic run_instr(input logic [2:0] f3, input logic rd_en, input logic wr_en,
                            input logic rw, input logic [4:0] rd, input logic [31:0] addr,
                            input logic [31:0] sdata, input int d, output int stalls);
      int n, k;
      bit mem_op, misal, access, abort, stalled, done, exp_ena;
      logic [31:0] exp_data, exp_wdata, w;
      logic [3:0]  exp_be;
      n        = size_bytes(f3);
      mem_op   = rd_en | wr_en;
      misal    = mem_op && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
      access   = mem_op && !misal;
      abort    = access && (d > TMO);
      exp_ena  = rw && !misal && !abort;
      exp_data = (rd_en && !wr_en) ? load_ref(f3, addr) : addr;
      exp_be   = 4'(((1 << n) - 1) << ((n == 4) ? 0 : addr[1:0]));
      exp_wdata = (n == 1) ? sdata[7:0] * 32'h01010101 :
                  (n == 2) ? sdata[15:0] * 32'h00010001 : sdata;
      ex_valid = 1'b1; ex_alu_out = addr; ex_rs2_data_st = sdata; ex_func3 = f3;
      ex_mem_read_ena = rd_en; ex_mem_write_ena = wr_en; ex_reg_write_ena = rw; ex_rd = rd;
      @(posedge clk); @(negedge clk);
      ex_valid = 1'b0; ex_alu_out = $urandom; ex_rs2_data_st = $urandom;
      ex_mem_read_ena = 1'($urandom); ex_mem_write_ena = 1'($urandom);
      ex_reg_write_ena = 1'($urandom); ex_rd = 5'($urandom);
      check("me_alu_out", me_alu_out, addr);
      check("me_rd", me_rd, rd);
      check("me_reg_write_ena", me_reg_write_ena, rw);
      stalls = 0; k = 0; done = 0;
      while (!done) begin
         dmem_ready = access && (k == d);
         dmem_rdata = dmem_ready ? rsp_word(dmem_addr >> 2) : $urandom;
         #1;
         check("dmem_req", dmem_req, access);
         if (access) begin
            check("dmem_we", dmem_we, wr_en);
            check("dmem_addr", dmem_addr, addr & ~32'd3);
            check("dmem_be", dmem_be, exp_be);
            if (wr_en) check("dmem_wdata", dmem_wdata, exp_wdata);
         end
         if (k > 0) begin
            check("wb_bubble", wb_reg_write_ena, 1'b0);
            check("misalign_pulse", me_misalign, 1'b0);
            check("bus_err_pulse", me_bus_err, 1'b0);
         end
         if (k == 0) begin
            obs_req = dmem_req; obs_we = dmem_we; obs_be = dmem_be; obs_wdata = dmem_wdata;
         end
         if (dmem_ready && dmem_we) begin
            w = rsp_word(dmem_addr >> 2);
            for (int i = 0; i < 4; i++)
               if (dmem_be[i]) w[8 * i +: 8] = dmem_wdata[8 * i +: 8];
            rsp_mem[dmem_addr >> 2] = w;
         end
         stalled = me_stall;
         if (stalled) stalls++;
         @(posedge clk); @(negedge clk);
         dmem_ready = 1'b0;
         if (!stalled) done = 1;
         k++;
         if (!done && k > TMO + 2) begin
            n_assert++; n_fail++;
            $error("FAIL stall_bound observed=%0d cycles expected<=%0d", k, TMO + 2);
            done = 1;
         end
      end
      check("stall_cycles", stalls, access ? ((d < TMO) ? d : TMO) : 0);
      check("wb_reg_write_ena", wb_reg_write_ena, exp_ena);
      check("wb_rd", wb_rd, rd);
      if (exp_ena) check("wb_reg_write_data", wb_reg_write_data, exp_data);
      check("me_misalign", me_misalign, misal);
      check("me_bus_err", me_bus_err, abort);
      if (access && !abort && wr_en)
         for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = 8'(sdata >> (8 * i));
   endtask

   initial begin
      int st;
      logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      rst = 1'b1; ex_valid = 1'b0; ex_alu_out = 32'h0; ex_rs2_data_st = 32'h0;
      ex_func3 = 3'b000; ex_mem_read_ena = 1'b0; ex_mem_write_ena = 1'b0;
      ex_reg_write_ena = 1'b0; ex_rd = 5'd0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_dmem_req", dmem_req, 1'b0);
      check("rst_me_stall", me_stall, 1'b0);
      check("rst_wb_ena", wb_reg_write_ena, 1'b0);
      check("rst_wb_data", wb_reg_write_data, 32'h0);
      check("rst_me_alu_out", me_alu_out, 32'h0);
      check("rst_me_reg_write", me_reg_write_ena, 1'b0);
      check("rst_pulses", {me_misalign, me_bus_err}, 2'b00);
      rst = 1'b0;

      preload(32'h100, 32'hDEADBEEF);
      run_instr(3'b010, 1'b1, 1'b0, 1'b1, 5'd1, 32'h100, 32'h0, 0, st);
      check("t1_data", wb_reg_write_data, 32'hDEADBEEF);
      check("t1_ena", wb_reg_write_ena, 1'b1);
      check("t1_stall", st, 0);

      preload(32'h100, 32'h80FF0000);
      run_instr(3'b000, 1'b1, 1'b0, 1'b1, 5'd2, 32'h103, 32'h0, 3, st);
      check("t2_lb_data", wb_reg_write_data, 32'hFFFFFF80);
      check("t2_lb_stall", st, 3);
      run_instr(3'b100, 1'b1, 1'b0, 1'b1, 5'd2, 32'h103, 32'h0, 3, st);
      check("t2_lbu_data", wb_reg_write_data, 32'h00000080);

      run_instr(3'b001, 1'b0, 1'b1, 1'b0, 5'd3, 32'h202, 32'h1234ABCD, 1, st);
      check("t3_be", obs_be, 4'b1100);
      check("t3_wdata", obs_wdata, 32'hABCDABCD);
      check("t3_we", obs_we, 1'b1);
      check("t3_wb_ena", wb_reg_write_ena, 1'b0);

      run_instr(3'b010, 1'b1, 1'b0, 1'b1, 5'd4, 32'h101, 32'h0, 0, st);
      check("t4_misalign", me_misalign, 1'b1);
      check("t4_req", obs_req, 1'b0);
      check("t4_wb_ena", wb_reg_write_ena, 1'b0);
      run_instr(3'b000, 1'b0, 1'b0, 1'b1, 5'd6, 32'h5555, 32'h0, 0, st);
      check("t4_next_stall", st, 0);
      check("t4_next_data", wb_reg_write_data, 32'h5555);

      run_instr(3'b010, 1'b1, 1'b0, 1'b1, 5'd7, 32'h104, 32'h0, 99, st);
      check("t5_stall", st, 4);
      check("t5_bus_err", me_bus_err, 1'b1);
      check("t5_wb_ena", wb_reg_write_ena, 1'b0);

      ex_valid = 1'b1; ex_alu_out = 32'h108; ex_func3 = 3'b010; ex_mem_read_ena = 1'b1;
      ex_mem_write_ena = 1'b0; ex_reg_write_ena = 1'b1; ex_rd = 5'd9;
      @(posedge clk); @(negedge clk);
      ex_valid = 1'b0;
      #1 check("t6_stall_idle", me_stall, 1'b1);
      @(posedge clk); @(negedge clk);
      check("t6_wait_req", dmem_req, 1'b1);
      check("t6_wait_stall", me_stall, 1'b1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      #1;
      check("t6_rst_req", dmem_req, 1'b0);
      check("t6_rst_stall", me_stall, 1'b0);
      check("t6_rst_wb", {wb_reg_write_ena, wb_rd, me_rd, me_reg_write_ena}, 32'h0);
      check("t6_rst_alu", me_alu_out, 32'h0);
      rst = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      @(posedge clk); @(negedge clk);
      dmem_ready = 1'b0;
      check("t6_late_ready_stall", me_stall, 1'b0);
      @(posedge clk); @(negedge clk);
      check("t6_late_ready_wb", wb_reg_write_ena, 1'b0);

      for (int it = 0; it < 150; it++) begin
         int op, d;
         logic [2:0] f3;
         logic [31:0] a;
         op = $urandom_range(0, 3);
         d  = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 3);
         a  = 32'h100 + 32'($urandom_range(0, 31));
         f3 = 3'($urandom_range(0, 2));
         case (op)
            0: run_instr(f3, 1'b0, 1'b0, 1'($urandom), 5'($urandom), $urandom, 32'h0, d, st);
            1: run_instr(ld_f3[$urandom_range(0, 4)], 1'b1, 1'b0, 1'b1, 5'($urandom), a, 32'h0, d, st);
            2: run_instr(f3, 1'b0, 1'b1, 1'b0, 5'($urandom), a, $urandom, d, st);
            default: run_instr(f3, 1'b1, 1'b1, 1'b0, 5'($urandom), a, $urandom, d, st);
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
